// File: rtl/vscale_fetch_queue_pkg.sv
// Shared constants for the vscale instruction fetch queue: register width,
// the canonical NOP encoding and the bit layout of one queue entry
// {badmem, pc, inst}.
package vscale_fetch_queue_pkg;

  localparam int XPR_LEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam int FQ_INST_LSB = 0;

  function automatic int fq_entry_width(input int xlen);
    return 2 * xlen + 1;
  endfunction

  function automatic int fq_pc_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int fq_badmem_bit(input int xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/vscale_fq_storage.sv
// Entry storage for the fetch queue: DEPTH x WIDTH register array with one
// write port and one asynchronous read port. Contents need no reset because
// validity is tracked by the pointers and count in the parent.
module vscale_fq_storage
  import vscale_fetch_queue_pkg::*;
#(
  parameter int WIDTH = fq_entry_width(XPR_LEN),
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Write decode: only the addressed entry takes the new word.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Entry registers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/vscale_fetch_queue.sv
// Instruction prefetch queue between the PC mux / imem port and the DX stage.
// Issues sequential fetches ahead of decode, buffers up to DEPTH words tagged
// with PC and access-fault flag, and flushes on redirect.
// Build option: define VSCALE_FQ_BYPASS_EN to let a response that arrives at
// an empty queue appear on the deq port in the same cycle.
module vscale_fetch_queue
  import vscale_fetch_queue_pkg::*;
#(
  parameter int              XLEN     = XPR_LEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_wait,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       imem_badmem_e,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_inst,
  output logic [XLEN-1:0]            deq_pc,
  output logic                       deq_badmem,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int EW      = fq_entry_width(XLEN);
  localparam int PC_LSB  = fq_pc_lsb(XLEN);
  localparam int BAD_BIT = fq_badmem_bit(XLEN);
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pending_q, pending_d;
  logic            drop_q, drop_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic [XLEN-1:0] redirect_addr;
  logic            resp_valid;
  logic            resp_keep;
  logic            q_empty;
  logic            bypass_hit;
  logic            deq_valid_int;
  logic            deq_from_q;
  logic            enq;
  logic            accept;
  logic [CW:0]     occ;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   rd_entry;

  // Handshake, bypass and request qualification for this cycle.
  always_comb begin
    redirect_addr = redirect_pc & ~XLEN'(3);
    resp_valid    = pending_q & ~imem_wait;
    // A response completing in a redirect cycle belongs to the old stream.
    resp_keep     = resp_valid & ~drop_q & ~redirect_valid;
    q_empty       = (count_q == '0);
`ifdef VSCALE_FQ_BYPASS_EN
    bypass_hit    = q_empty & resp_keep;
`else
    bypass_hit    = 1'b0;
`endif
    deq_valid_int = ~redirect_valid & (~q_empty | bypass_hit);
    deq_from_q    = deq_valid_int & deq_ready & ~q_empty;
    enq           = resp_keep & ~(bypass_hit & deq_ready);
    // Slots committed after this cycle: stored words plus the one in flight.
    occ = (CW+1)'(count_q) + (CW+1)'(pending_q & imem_wait)
        + (CW+1)'(enq) - (CW+1)'(deq_from_q);
    if (redirect_valid) begin
      imem_req = ~(pending_q & imem_wait);
    end else begin
      // A faulting word stops the stream at once, not one fetch later.
      imem_req = ~halted_q & ~drop_q & ~(resp_keep & imem_badmem_e)
               & (occ < DEPTH_C);
    end
    imem_addr = redirect_valid ? redirect_addr : fetch_pc_q;
    accept    = imem_req & ~(pending_q & imem_wait);
  end

  // Next-state for the fetch stream, flags and queue pointers.
  always_comb begin
    pending_d  = accept | (pending_q & imem_wait);
    pend_pc_d  = accept ? imem_addr : pend_pc_q;
    fetch_pc_d = accept ? (imem_addr + XLEN'(4))
               : (redirect_valid ? redirect_addr : fetch_pc_q);
    if (redirect_valid) begin
      drop_d   = pending_q & imem_wait;
      halted_d = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      drop_d   = resp_valid ? 1'b0 : drop_q;
      halted_d = (resp_keep & imem_badmem_e) | halted_q;
      rd_ptr_d = rd_ptr_q + PW'(deq_from_q);
      wr_ptr_d = wr_ptr_q + PW'(enq);
      count_d  = count_q + CW'(enq) - CW'(deq_from_q);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= 1'b0;
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  // Pack the arriving word with its PC and fault flag.
  always_comb begin
    wr_entry                         = '0;
    wr_entry[FQ_INST_LSB +: XLEN]    = imem_rdata;
    wr_entry[PC_LSB +: XLEN]         = pend_pc_q;
    wr_entry[BAD_BIT]                = imem_badmem_e;
  end

  vscale_fq_storage #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (enq),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

  // Head presentation: bypassed response, stored head, or NOP when idle.
  always_comb begin
    deq_inst   = XLEN'(RV_NOP);
    deq_pc     = '0;
    deq_badmem = 1'b0;
    if (bypass_hit) begin
      deq_inst   = imem_rdata;
      deq_pc     = pend_pc_q;
      deq_badmem = imem_badmem_e;
    end else if (deq_valid_int) begin
      deq_inst   = rd_entry[FQ_INST_LSB +: XLEN];
      deq_pc     = rd_entry[PC_LSB +: XLEN];
      deq_badmem = rd_entry[BAD_BIT];
    end
  end

  assign deq_valid = deq_valid_int;
  assign count     = count_q;

endmodule
